// File: rtl/bp_be_pkg.sv
// Shared types for the backend dual-issue scheduler.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_run    = 2'd0,
        e_serial = 2'd1,
        e_flush  = 2'd2
    } bp_be_dual_sched_state_e;

    localparam int bp_be_reg_id_width_gp = 6;

endpackage

// File: rtl/bp_be_pair_check.sv
// Combinational legality check for pairing slot 2 behind slot 1 in one cycle.
module bp_be_pair_check #(
    parameter int reg_id_width_p = 6
) (
    input  logic                      rd_w_v_1_i,
    input  logic [reg_id_width_p-1:0] rd_1_i,
    input  logic                      mem_v_1_i,
    input  logic                      csr_v_1_i,
    input  logic                      fence_v_1_i,
    input  logic                      long_v_1_i,
    input  logic [reg_id_width_p-1:0] rs1_2_i,
    input  logic [reg_id_width_p-1:0] rs2_2_i,
    input  logic [reg_id_width_p-1:0] rs3_2_i,
    input  logic                      rs1_v_2_i,
    input  logic                      rs2_v_2_i,
    input  logic                      rs3_v_2_i,
    input  logic                      mem_v_2_i,
    input  logic                      csr_v_2_i,
    input  logic                      fence_v_2_i,
    input  logic                      long_v_2_i,
    output logic                      pair_ok_o
);

    logic wr_live;
    logic raw;
    logic serial;
    logic struct_conflict;

    always_comb begin
        // Int x0 is never a real producer; fp reg 0 (id with fp bit set) is.
        wr_live         = rd_w_v_1_i & (rd_1_i != '0);
        raw             = wr_live & ((rs1_v_2_i & (rs1_2_i == rd_1_i))
                                   | (rs2_v_2_i & (rs2_2_i == rd_1_i))
                                   | (rs3_v_2_i & (rs3_2_i == rd_1_i)));
        serial          = csr_v_1_i | fence_v_1_i | csr_v_2_i | fence_v_2_i;
        struct_conflict = (mem_v_1_i & mem_v_2_i) | (long_v_1_i & long_v_2_i);
        pair_ok_o       = ~raw & ~serial & ~struct_conflict;
    end

endmodule

// File: rtl/bp_be_dual_issue_scheduler.sv
// Picks zero, one or two instructions per cycle from the fe queue head and
// tracks serializing instructions and outstanding long-unit results.
module bp_be_dual_issue_scheduler
    import bp_be_pkg::*;
#(
    parameter int reg_id_width_p = bp_be_reg_id_width_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      suppress_i,
    input  logic                      flush_i,
    input  logic                      commit_serial_i,
    input  logic                      long_done_v_i,
    input  logic [reg_id_width_p-1:0] long_done_rd_i,

    input  logic                      v1_i,
    input  logic [reg_id_width_p-1:0] rs1_1_i,
    input  logic [reg_id_width_p-1:0] rs2_1_i,
    input  logic [reg_id_width_p-1:0] rs3_1_i,
    input  logic [reg_id_width_p-1:0] rd_1_i,
    input  logic                      rs1_v_1_i,
    input  logic                      rs2_v_1_i,
    input  logic                      rs3_v_1_i,
    input  logic                      rd_w_v_1_i,
    input  logic                      mem_v_1_i,
    input  logic                      csr_v_1_i,
    input  logic                      fence_v_1_i,
    input  logic                      long_v_1_i,

    input  logic                      v2_i,
    input  logic [reg_id_width_p-1:0] rs1_2_i,
    input  logic [reg_id_width_p-1:0] rs2_2_i,
    input  logic [reg_id_width_p-1:0] rs3_2_i,
    input  logic [reg_id_width_p-1:0] rd_2_i,
    input  logic                      rs1_v_2_i,
    input  logic                      rs2_v_2_i,
    input  logic                      rs3_v_2_i,
    input  logic                      rd_w_v_2_i,
    input  logic                      mem_v_2_i,
    input  logic                      csr_v_2_i,
    input  logic                      fence_v_2_i,
    input  logic                      long_v_2_i,

    output logic                      yumi1_o,
    output logic                      yumi2_o,
    output logic                      issue_v1_o,
    output logic                      issue_v2_o,
    output logic                      dual_o,
    output logic                      serial_busy_o,
    output bp_be_dual_sched_state_e   state_o
);

    localparam int num_regs_lp = 2 ** reg_id_width_p;

    bp_be_dual_sched_state_e state_r, state_n;

    logic [num_regs_lp-1:0] busy_r, busy_n, busy_eff, done_mask;
    logic                   long_busy_r, long_busy_n;

    logic                      can_issue;
    logic                      slot1_ok, slot2_ok, pair_ok;
    logic                      long_issue, long_rd_w_v;
    logic [reg_id_width_p-1:0] long_rd;

    function automatic logic src_blocked(input logic                      en,
                                         input logic [reg_id_width_p-1:0] rs,
                                         input logic [num_regs_lp-1:0]    busy);
        return en & busy[rs] & (rs != '0);
    endfunction

    // A writeback landing this cycle releases its consumers in the same cycle.
    always_comb begin
        done_mask = '0;
        if (long_done_v_i) begin
            done_mask[long_done_rd_i] = 1'b1;
        end
        busy_eff = busy_r & ~done_mask;
    end

    always_comb begin
        can_issue = reset_n_i & (state_r == e_run) & ~suppress_i & ~flush_i;

        slot1_ok = v1_i
                 & ~src_blocked(rs1_v_1_i, rs1_1_i, busy_eff)
                 & ~src_blocked(rs2_v_1_i, rs2_1_i, busy_eff)
                 & ~src_blocked(rs3_v_1_i, rs3_1_i, busy_eff)
                 & ~(long_v_1_i & long_busy_r & ~long_done_v_i);

        slot2_ok = v2_i
                 & ~src_blocked(rs1_v_2_i, rs1_2_i, busy_eff)
                 & ~src_blocked(rs2_v_2_i, rs2_2_i, busy_eff)
                 & ~src_blocked(rs3_v_2_i, rs3_2_i, busy_eff)
                 & ~(long_v_2_i & long_busy_r & ~long_done_v_i);
    end

    bp_be_pair_check #(
        .reg_id_width_p(reg_id_width_p)
    ) pair_check (
        .rd_w_v_1_i (rd_w_v_1_i),
        .rd_1_i     (rd_1_i),
        .mem_v_1_i  (mem_v_1_i),
        .csr_v_1_i  (csr_v_1_i),
        .fence_v_1_i(fence_v_1_i),
        .long_v_1_i (long_v_1_i),
        .rs1_2_i    (rs1_2_i),
        .rs2_2_i    (rs2_2_i),
        .rs3_2_i    (rs3_2_i),
        .rs1_v_2_i  (rs1_v_2_i),
        .rs2_v_2_i  (rs2_v_2_i),
        .rs3_v_2_i  (rs3_v_2_i),
        .mem_v_2_i  (mem_v_2_i),
        .csr_v_2_i  (csr_v_2_i),
        .fence_v_2_i(fence_v_2_i),
        .long_v_2_i (long_v_2_i),
        .pair_ok_o  (pair_ok)
    );

    // Handshake: the queue presents v1/v2 and holds them until accepted; yumi is
    // a same-cycle accept that only rises with its valid, in slot order.
    always_comb begin
        yumi1_o       = can_issue & slot1_ok;
        yumi2_o       = yumi1_o & slot2_ok & pair_ok;
        issue_v1_o    = yumi1_o;
        issue_v2_o    = yumi2_o;
        dual_o        = yumi2_o;
        serial_busy_o = reset_n_i & ~flush_i & (state_r == e_serial);
        state_o       = state_r;
    end

    // At most one long op issues per cycle, so a single set port suffices.
    always_comb begin
        long_issue  = (yumi1_o & long_v_1_i) | (yumi2_o & long_v_2_i);
        long_rd     = (yumi1_o & long_v_1_i) ? rd_1_i : rd_2_i;
        long_rd_w_v = (yumi1_o & long_v_1_i) ? rd_w_v_1_i : rd_w_v_2_i;

        busy_n = busy_eff;
        if (long_issue & long_rd_w_v & (long_rd != '0)) begin
            busy_n[long_rd] = 1'b1;
        end

        long_busy_n = long_busy_r;
        if (long_issue) begin
            long_busy_n = 1'b1;
        end else if (long_done_v_i) begin
            long_busy_n = 1'b0;
        end

        if (flush_i) begin
            busy_n      = '0;
            long_busy_n = 1'b0;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_run:    if (yumi1_o & (csr_v_1_i | fence_v_1_i)) state_n = e_serial;
            e_serial: if (commit_serial_i) state_n = e_run;
            e_flush:  state_n = e_run;
            default:  state_n = e_run;
        endcase
        if (flush_i) begin
            state_n = e_flush;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= e_run;
            busy_r      <= '0;
            long_busy_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            busy_r      <= busy_n;
            long_busy_r <= long_busy_n;
        end
    end

endmodule

// File: tb/tb_bp_be_dual_issue_scheduler.sv
// Self-checking bench for bp_be_dual_issue_scheduler: vector table plus sequences.
module tb_bp_be_dual_issue_scheduler;
    import bp_be_pkg::*;

    typedef struct packed {
        logic       v;
        logic [5:0] rs1, rs2, rs3, rd;
        logic       rs1_v, rs2_v, rs3_v, rd_w_v;
        logic       mem, csr, fence, lng;
    } slot_t;

    typedef struct {
        string name;
        logic  sup;
        slot_t a;
        slot_t b;
        logic  y1;
        logic  y2;
    } vec_t;

    localparam logic [3:0] C_ALU = 4'b0000, C_MEM = 4'b1000, C_CSR = 4'b0100,
                           C_FENCE = 4'b0010, C_LONG = 4'b0001;

    logic clk, rst_n, suppress, flush, commit, ldv;
    logic [5:0] ldrd;
    slot_t s1, s2;

    logic y1, y2, iv1, iv2, dual, sbusy;
    bp_be_dual_sched_state_e state;

    logic [5:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    vec_t vecs[15];

    bp_be_dual_issue_scheduler #(.reg_id_width_p(6)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .suppress_i(suppress), .flush_i(flush),
        .commit_serial_i(commit), .long_done_v_i(ldv), .long_done_rd_i(ldrd),
        .v1_i(s1.v), .rs1_1_i(s1.rs1), .rs2_1_i(s1.rs2), .rs3_1_i(s1.rs3), .rd_1_i(s1.rd),
        .rs1_v_1_i(s1.rs1_v), .rs2_v_1_i(s1.rs2_v), .rs3_v_1_i(s1.rs3_v), .rd_w_v_1_i(s1.rd_w_v),
        .mem_v_1_i(s1.mem), .csr_v_1_i(s1.csr), .fence_v_1_i(s1.fence), .long_v_1_i(s1.lng),
        .v2_i(s2.v), .rs1_2_i(s2.rs1), .rs2_2_i(s2.rs2), .rs3_2_i(s2.rs3), .rd_2_i(s2.rd),
        .rs1_v_2_i(s2.rs1_v), .rs2_v_2_i(s2.rs2_v), .rs3_v_2_i(s2.rs3_v), .rd_w_v_2_i(s2.rd_w_v),
        .mem_v_2_i(s2.mem), .csr_v_2_i(s2.csr), .fence_v_2_i(s2.fence), .long_v_2_i(s2.lng),
        .yumi1_o(y1), .yumi2_o(y2), .issue_v1_o(iv1), .issue_v2_o(iv2),
        .dual_o(dual), .serial_busy_o(sbusy), .state_o(state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic slot_t mk(input logic v, input logic [5:0] rd, input logic rdw,
                                 input logic [5:0] rs1, input logic rs1v,
                                 input logic [5:0] rs2, input logic rs2v,
                                 input logic [3:0] cls);
        slot_t s;
        s.v = v; s.rd = rd; s.rd_w_v = rdw;
        s.rs1 = rs1; s.rs1_v = rs1v; s.rs2 = rs2; s.rs2_v = rs2v;
        s.rs3 = 6'd0; s.rs3_v = 1'b0;
        {s.mem, s.csr, s.fence, s.lng} = cls;
        return s;
    endfunction

    function automatic slot_t none();
        return mk(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, C_ALU);
    endfunction

    function automatic logic [5:0] exp_of(input logic ey1, input logic ey2, input logic esb);
        return {ey1, ey2, ey1, ey2, ey2, esb};
    endfunction

    // Scoreboard
    task automatic check_out(input string name);
        logic [5:0] exp, obs;
        obs = {y1, y2, iv1, iv2, dual, sbusy};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected entry queued, got %b", name, obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s: {y1,y2,iv1,iv2,dual,sb} got %b want %b", name, obs, exp);
            end
        end
    endtask

    task automatic chk_state(input string name, input bp_be_dual_sched_state_e e);
        checks++;
        if (state !== e) begin
            failures++;
            $display("FAIL %s: state got %0d want %0d", name, state, e);
        end
    endtask

    // Driver: inputs already set at the falling edge; sample 2 units later.
    task automatic cyc(input string name, input logic ey1, input logic ey2, input logic esb);
        exp_q.push_back(exp_of(ey1, ey2, esb));
        #2;
        check_out(name);
        @(negedge clk);
        flush = 1'b0; commit = 1'b0; ldv = 1'b0; ldrd = 6'd0;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        slot_t t;
        vecs[0]  = '{"v1_low",        0, none(),                              mk(1,6,1,7,1,8,1,C_ALU), 0, 0};
        vecs[1]  = '{"dual_add",      0, mk(1,5,1,1,1,2,1,C_ALU),             mk(1,6,1,7,1,8,1,C_ALU), 1, 1};
        vecs[2]  = '{"raw_rs1",       0, mk(1,5,1,1,1,2,1,C_ALU),             mk(1,6,1,5,1,8,1,C_ALU), 1, 0};
        vecs[3]  = '{"raw_rs2",       0, mk(1,5,1,1,1,2,1,C_ALU),             mk(1,6,1,7,1,5,1,C_ALU), 1, 0};
        t = mk(1,6,1,7,1,8,1,C_ALU); t.rs3 = 6'd5; t.rs3_v = 1'b1;
        vecs[4]  = '{"raw_rs3",       0, mk(1,5,1,1,1,2,1,C_ALU),             t,                       1, 0};
        vecs[5]  = '{"raw_src_off",   0, mk(1,5,1,1,1,2,1,C_ALU),             mk(1,6,1,5,0,8,1,C_ALU), 1, 1};
        vecs[6]  = '{"raw_int_x0",    0, mk(1,0,1,1,1,2,1,C_ALU),             mk(1,6,1,0,1,8,1,C_ALU), 1, 1};
        vecs[7]  = '{"raw_fp_f0",     0, mk(1,32,1,1,1,2,1,C_ALU),            mk(1,6,1,32,1,8,1,C_ALU), 1, 0};
        vecs[8]  = '{"raw_no_write",  0, mk(1,5,0,1,1,2,1,C_ALU),             mk(1,6,1,5,1,8,1,C_ALU), 1, 1};
        vecs[9]  = '{"mem_mem",       0, mk(1,5,1,1,1,2,1,C_MEM),             mk(1,6,1,7,1,8,1,C_MEM), 1, 0};
        vecs[10] = '{"mem_alu",       0, mk(1,5,1,1,1,2,1,C_MEM),             mk(1,6,1,7,1,8,1,C_ALU), 1, 1};
        vecs[11] = '{"suppress",      1, mk(1,5,1,1,1,2,1,C_ALU),             mk(1,6,1,7,1,8,1,C_ALU), 0, 0};
        vecs[12] = '{"v2_low",        0, mk(1,5,1,1,1,2,1,C_ALU),             none(),                  1, 0};
        vecs[13] = '{"slot2_csr",     0, mk(1,5,1,1,1,2,1,C_ALU),             mk(1,6,1,7,1,8,1,C_CSR), 1, 0};
        vecs[14] = '{"slot2_fence",   0, mk(1,5,1,1,1,2,1,C_ALU),             mk(1,6,0,7,0,8,0,C_FENCE), 1, 0};

        rst_n = 1'b0; suppress = 1'b0; flush = 1'b0; commit = 1'b0; ldv = 1'b0; ldrd = 6'd0;
        s1 = mk(1,5,1,1,1,2,1,C_ALU); s2 = mk(1,6,1,7,1,8,1,C_ALU);
        #3;
        exp_q.push_back(exp_of(0, 0, 0));
        check_out("reset_outputs");
        chk_state("reset_state", e_run);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            suppress = vecs[i].sup; s1 = vecs[i].a; s2 = vecs[i].b;
            cyc(vecs[i].name, vecs[i].y1, vecs[i].y2, 1'b0);
        end
        suppress = 1'b0;

        // RAW split, then former slot 2 issues as slot 1
        s1 = mk(1,5,1,1,1,2,1,C_ALU); s2 = mk(1,6,1,5,1,8,1,C_ALU);
        cyc("raw_split", 1, 0, 0);
        s1 = mk(1,6,1,5,1,8,1,C_ALU); s2 = none();
        cyc("raw_follow", 1, 0, 0);

        // Divide result hazard with same-cycle bypass
        s1 = mk(1,9,1,1,1,2,1,C_LONG);
        cyc("div_x9", 1, 0, 0);
        s1 = mk(1,1,1,9,1,2,1,C_ALU);
        cyc("x9_stall_a", 0, 0, 0);
        cyc("x9_stall_b", 0, 0, 0);
        ldv = 1'b1; ldrd = 6'd9;
        cyc("x9_bypass", 1, 0, 0);

        // Long unit occupancy and set-over-clear on the same rd
        s1 = mk(1,10,1,0,0,0,0,C_LONG);
        cyc("div_x10", 1, 0, 0);
        s1 = mk(1,11,1,0,0,0,0,C_LONG);
        cyc("long_unit_busy", 0, 0, 0);
        ldv = 1'b1; ldrd = 6'd10;
        cyc("long_done_frees_unit", 1, 0, 0);
        ldv = 1'b1; ldrd = 6'd11;
        cyc("long_reissue_same_rd", 1, 0, 0);
        s1 = mk(1,1,1,11,1,0,0,C_ALU);
        cyc("set_wins_stall", 0, 0, 0);
        ldv = 1'b1; ldrd = 6'd11;
        cyc("set_wins_release", 1, 0, 0);

        // Two long ops never pair; slot 2 blocked on busy source
        s1 = mk(1,13,1,0,0,0,0,C_LONG); s2 = mk(1,14,1,0,0,0,0,C_LONG);
        cyc("long_long", 1, 0, 0);
        s1 = mk(1,1,1,0,0,0,0,C_ALU); s2 = mk(1,2,1,13,1,0,0,C_ALU);
        cyc("slot2_busy_src", 1, 0, 0);
        s1 = none(); s2 = none(); ldv = 1'b1; ldrd = 6'd13;
        cyc("drain_x13", 0, 0, 0);

        // Slot 2 long op sets the scoreboard
        s1 = mk(1,1,1,0,0,0,0,C_ALU); s2 = mk(1,14,1,0,0,0,0,C_LONG);
        cyc("slot2_long_dual", 1, 1, 0);
        s1 = mk(1,2,1,14,1,0,0,C_ALU); s2 = none();
        cyc("slot2_long_stall", 0, 0, 0);
        ldv = 1'b1; ldrd = 6'd14;
        cyc("slot2_long_release", 1, 0, 0);

        // CSR serialization
        s1 = mk(1,3,1,0,0,0,0,C_CSR); s2 = mk(1,6,1,7,1,8,1,C_ALU);
        cyc("csr_single", 1, 0, 0);
        chk_state("csr_enters_serial", e_serial);
        s1 = mk(1,1,1,0,0,0,0,C_ALU); s2 = mk(1,2,1,0,0,0,0,C_ALU);
        for (int i = 0; i < 3; i++) cyc("serial_hold", 0, 0, 1);
        commit = 1'b1;
        cyc("serial_commit", 0, 0, 1);
        cyc("serial_resume", 1, 1, 0);

        // Flush from e_serial with a busy register
        s1 = mk(1,9,1,0,0,0,0,C_LONG); s2 = none();
        cyc("flush_div_x9", 1, 0, 0);
        s1 = mk(1,3,1,0,0,0,0,C_FENCE);
        cyc("fence_single", 1, 0, 0);
        s1 = mk(1,1,1,9,1,0,0,C_ALU); s2 = mk(1,6,1,7,1,8,1,C_ALU); flush = 1'b1;
        cyc("flush_cycle", 0, 0, 0);
        chk_state("flush_state", e_flush);
        cyc("flush_dead", 0, 0, 0);
        chk_state("after_flush_state", e_run);
        cyc("flush_dual_resume", 1, 1, 0);
        s1 = mk(1,15,1,0,0,0,0,C_LONG); s2 = none();
        cyc("flush_freed_long", 1, 0, 0);
        s1 = none(); ldv = 1'b1; ldrd = 6'd15;
        cyc("drain_x15", 0, 0, 0);

        // Asynchronous reset mid-cycle
        s1 = mk(1,9,1,0,0,0,0,C_LONG);
        cyc("pre_reset_div", 1, 0, 0);
        s1 = mk(1,3,1,0,0,0,0,C_CSR);
        cyc("pre_reset_csr", 1, 0, 0);
        s1 = mk(1,1,1,9,1,0,0,C_ALU); s2 = mk(1,16,1,0,0,0,0,C_LONG);
        exp_q.push_back(exp_of(0, 0, 1));
        #2;
        check_out("pre_reset_hold");
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(exp_of(0, 0, 0));
        check_out("reset_midcycle");
        chk_state("reset_midcycle_state", e_run);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_reset_dual", 1, 1, 0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL exp_q_drained: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
